// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA are queued in a FIFO
// and serialised on tx; STATUS exposes count, overflow, full and busy.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
  output logic        hit,
  output logic        tx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0] LAST_TICK   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT         state, nextState;
  logic [7:0]    shift, shiftNext;
  logic [BW-1:0] bitCnt, bitCntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic          txNext;

  logic [7:0]    fifoMem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          overflow;

  logic dataHit, statusHit, full, empty, busy, push, pop, overflowSet, bitEnd;
  logic [7:0] countByte;
  logic unusedBits;

  assign unusedBits  = ^writeData[31:8];
  assign dataHit     = (address == BASE_ADDR);
  assign statusHit   = (address == STATUS_ADDR);
  assign hit         = dataHit | statusHit;
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign busy        = (state != IDLE) | ~empty;
  assign push        = memWrite & dataHit & ~full;
  assign overflowSet = memWrite & dataHit & full;
  assign bitEnd      = (bitCnt == LAST_TICK);
  assign countByte   = 8'(count);

  // STATUS shows pre-edge register state; every other read returns zero.
  always_comb begin
    readData = 32'h0;
    if (memRead && statusHit)
      readData = {16'h0, countByte, 5'b0, overflow, full, busy};
  end

  // Serializer next-state logic; tx is registered from the next state so it never glitches.
  always_comb begin
    nextState  = state;
    shiftNext  = shift;
    bitIdxNext = bitIdx;
    bitCntNext = bitEnd ? '0 : bitCnt + BW'(1);
    pop        = 1'b0;
    case (state)
      IDLE: begin
        bitCntNext = '0;
        if (!empty) begin
          pop       = 1'b1;
          nextState = START;
          shiftNext = fifoMem[rdPtr];
        end
      end
      START: begin
        if (bitEnd) begin
          nextState  = DATA;
          bitIdxNext = 3'd0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx == 3'd7) begin
            nextState = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = {1'b0, shift[7:1]};
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (!empty) begin
            pop       = 1'b1;
            nextState = START;
            shiftNext = fifoMem[rdPtr];
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
    case (nextState)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= 8'h0;
      bitCnt   <= '0;
      bitIdx   <= 3'd0;
      tx       <= 1'b1;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= nextState;
      shift  <= shiftNext;
      bitCnt <= bitCntNext;
      bitIdx <= bitIdxNext;
      tx     <= txNext;
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped store on the same edge as a STATUS read keeps overflow set.
      if (overflowSet)
        overflow <= 1'b1;
      else if (memRead && statusHit)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= writeData[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: waveform-queue reference model compared
// every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = BASE + 32'd4;
  localparam int DEPTH = 8;
  localparam int CPB   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writeData, readData;
  logic        memRead, memWrite, hit, tx;

  int vectors = 0;
  int miscompares = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .readData(readData), .hit(hit), .tx(tx)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue for the FIFO and a per-cycle queue of line levels for the frame in flight.
  logic [7:0] mq[$];
  logic       wave[$];
  logic       mOvf = 1'b0;
  logic       modelValid = 1'b0;

  always @(posedge clk) begin
    logic fullBefore;
    logic [7:0] b;
    logic lvl;
    if (reset) begin
      mq.delete();
      wave.delete();
      mOvf = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      fullBefore = (mq.size() == DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && mq.size() > 0) begin
        b = mq.pop_front();
        for (int j = 0; j < 10; j++) begin
          lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
          for (int c = 0; c < CPB; c++) wave.push_back(lvl);
        end
      end
      if (memRead && address == STATUS) mOvf = 1'b0;
      if (memWrite && address == BASE) begin
        if (fullBefore) mOvf = 1'b1;
        else mq.push_back(writeData[7:0]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] expRd;
    logic expTx, expHit, expFull, expBusy;
    if (modelValid) begin
      expTx   = (wave.size() > 0) ? wave[0] : 1'b1;
      expHit  = (address == BASE) || (address == STATUS);
      expFull = (mq.size() == DEPTH);
      expBusy = (wave.size() > 0) || (mq.size() > 0);
      expRd   = 32'h0;
      if (memRead && address == STATUS)
        expRd = {16'h0, 8'(mq.size()), 5'b0, mOvf, expFull, expBusy};
      checkOutput("model tx", {31'h0, tx}, {31'h0, expTx});
      checkOutput("model hit", {31'h0, hit}, {31'h0, expHit});
      checkOutput("model readData", readData, expRd);
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    address = a;
    writeData = d;
    memRead = rd;
    memWrite = wr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic storeByte(input logic [7:0] b);
    applyStimulus(BASE, {24'h0, b}, 1'b0, 1'b1);
    tick(1);
  endtask

  logic frame41 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    tick(2);
    reset = 1'b0;

    // Reset state
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("reset hit", {31'h0, hit}, 32'h1);
    checkOutput("reset status", readData, 32'h0);
    checkOutput("reset tx", {31'h0, tx}, 32'h1);
    tick(2);

    // Single frame 0x41 with STATUS polled throughout
    storeByte(8'h41);
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      checkOutput("frame41 tx", {31'h0, tx}, {31'h0, frame41[i/4]});
      checkOutput("frame41 busy", readData, 32'h1);
    end
    tick(1);
    checkOutput("frame41 idle status", readData, 32'h0);
    checkOutput("frame41 idle tx", {31'h0, tx}, 32'h1);

    // Ten back-to-back stores into an 8-deep FIFO
    for (int i = 0; i < 10; i++) storeByte(8'h30 + 8'(i));
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("overflow status", readData, 32'h0000_0807);
    tick(1);
    checkOutput("overflow cleared", readData, 32'h0000_0803);
    tick(350);
    checkOutput("nine frames busy", readData, 32'h1);
    tick(1);
    checkOutput("nine frames done", readData, 32'h0);
    tick(3);

    // Two contiguous frames
    storeByte(8'h55);
    storeByte(8'hAA);
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    tick(79);
    checkOutput("two frames busy", readData, 32'h1);
    tick(1);
    checkOutput("two frames done", readData, 32'h0);
    tick(3);

    // Reset during data bit 3 with two bytes still queued
    storeByte(8'hC3);
    storeByte(8'h11);
    storeByte(8'h22);
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    tick(16);
    checkOutput("pre-reset status", readData, 32'h0000_0201);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("post-reset tx", {31'h0, tx}, 32'h1);
    checkOutput("post-reset status", readData, 32'h0);
    tick(100);
    checkOutput("no frames after reset", {31'h0, tx}, 32'h1);
    checkOutput("still idle after reset", readData, 32'h0);

    // Off-map addresses
    applyStimulus(BASE + 32'd8, 32'h77, 1'b1, 1'b1);
    #1;
    checkOutput("base+8 hit", {31'h0, hit}, 32'h0);
    checkOutput("base+8 readData", readData, 32'h0);
    tick(1);
    applyStimulus(BASE + 32'd1, 32'h66, 1'b1, 1'b1);
    #1;
    checkOutput("base+1 hit", {31'h0, hit}, 32'h0);
    checkOutput("base+1 readData", readData, 32'h0);
    tick(1);
    applyStimulus(BASE, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("data read hit", {31'h0, hit}, 32'h1);
    checkOutput("data read zero", readData, 32'h0);
    applyStimulus(STATUS, 32'h0, 1'b1, 1'b0);
    tick(3);
    checkOutput("no enqueue status", readData, 32'h0);
    checkOutput("no enqueue tx", {31'h0, tx}, 32'h1);

    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the CPU data-memory bus as a responder next to the data memory. The CPU stores bytes into a DATA register; they are queued in an internal FIFO and serialised 8N1 on `tx`. A STATUS register lets software poll busy, full and overflow. The system decodes `hit` to steer `readData` between this block and the data memory.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: byte address of DATA; STATUS is at `BASE_ADDR+4`.
- `DEPTH`, 8: FIFO entries; power of two, 2..128.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; must be ≥2.

- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address` input 32: CPU data address.
- `writeData` input 32: CPU store data; only bits [7:0] used.
- `memRead` input 1: CPU load strobe.
- `memWrite` input 1: CPU store strobe.
- `readData` output 32: load data; combinational.
- `hit` output 1: combinational; 1 when `address` equals DATA or STATUS exactly (all 32 bits).
- `tx` output 1: serial line; idles high.

## Operation
- The block does not interpret bus size mode. Stores of any size to DATA enqueue `writeData[7:0]`. STATUS reads always return the full word.
- Write path: on an edge with `memWrite` and `address==BASE_ADDR`:
  - FIFO not full (sampled before the edge): enqueue.
  - FIFO full: drop the byte and set sticky `overflow`. This applies even if a pop happens on the same edge.
- Stores to STATUS are ignored.
- Read path, combinational:
  - `memRead` and `address==BASE_ADDR+4`: `readData`={16'b0, count[7:0], 5'b0, overflow, full, busy}.
  - `count` is the number of FIFO entries, 0..DEPTH.
  - `busy` = serializer not IDLE or FIFO non-empty.
  - `full` = count==DEPTH.
  - Any other read, including DATA and when `memRead`=0: `readData`=0.
- Overflow clear: an edge with `memRead` to STATUS clears `overflow`. If an overflowing write occurs on the same edge, set wins.
- Serializer states:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0], 8 bits LSB first.
  - STOP: `tx`=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, tracked by a bit-cycle counter and a 3-bit bit index.
- Transitions:
  - IDLE → START on an edge where the FIFO is non-empty. That edge pops the head into `shift`.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → exit on its last cycle's edge: to START with a pop if the FIFO is non-empty (no idle gap), otherwise to IDLE.
- FIFO: circular buffer with wrapping read/write pointers. A simultaneous push and pop keeps `count` unchanged.
- `tx` is driven from a register and is glitch-free.

## Timing
- Reset, applied on the edge: `tx`=1, state IDLE, FIFO empty, `count`=0, `overflow`=0, counters 0. `readData`/`hit` follow the combinational rules, so STATUS reads 0.
- Reset mid-frame aborts the frame and discards queued bytes; `tx`=1 from the cycle after the reset edge.
- Store at edge k to an idle block: pop at edge k+1, `tx` low from k+1 for CLKS_PER_BIT cycles.
- Frame length is 10×CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Capacity with the serializer draining: DEPTH+1 consecutive single-cycle stores are accepted from idle, because the first byte leaves the FIFO one edge after entry.
- STATUS reflects register state before the current edge, with zero-cycle read latency, consistent with the single-cycle CPU.

## Test plan
- Reset, then read STATUS at BASE+4 → `hit`=1, `readData`=0x00000000, `tx`=1.
- CLKS_PER_BIT=4: store 0x41 to BASE → `tx` low from the next cycle for 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then 1 for 4 cycles. STATUS bit0 is 1 throughout and returns to 0 after cycle 40.
- DEPTH=8: 10 stores on consecutive cycles (0x30..0x39) →
  - After the 10th store: STATUS `count`=8, full=1, overflow=1.
  - Exactly 9 frames, 0x30..0x38, are sent contiguously.
  - A STATUS read clears overflow on the following cycle.
- Two stores, 0x55 then 0xAA → second start bit immediately follows the first stop bit; total 80 cycles.
- Assert `reset` during DATA bit 3 of a frame with 2 bytes queued → `tx`=1 next cycle, STATUS=0, no further frames.
- Read/write at BASE+8 and BASE+1 → `hit`=0, `readData`=0; no enqueue and no state change.
